// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM states and constants shared by the
// iterative multiply/divide unit and its bench.
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [2:0] MDU_OP_NOP   = 3'b000;
  localparam logic [2:0] MDU_OP_MULT  = 3'b001;
  localparam logic [2:0] MDU_OP_MULTU = 3'b010;
  localparam logic [2:0] MDU_OP_DIV   = 3'b011;
  localparam logic [2:0] MDU_OP_DIVU  = 3'b100;
  localparam logic [2:0] MDU_OP_MTHI  = 3'b101;
  localparam logic [2:0] MDU_OP_MTLO  = 3'b110;
  localparam logic [2:0] MDU_OP_NOP7  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam logic [MDU_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negation.
// i_val/i_neg in, o_val = i_neg ? -i_val : i_val.
module mdu_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative shift-add multiplier / restoring
// divider with HI/LO registers and pipeline stall.
// Ports: clk, rst_n (sync, low); req_valid/req_op/Op1/Op2,
// hilo_rd, flush in; req_ready, busy, done, Stall, HI, LO out.
import mdu_pkg::*;

module mdu_sequencer #(
  parameter int WIDTH = MDU_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r;
  logic               r_div0, r_done;

  logic w_mul, w_div, w_sgn, w_mthi, w_mtlo;
  logic w_take, w_start, w_fix_wr;

  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_sum, w_shl, w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;

  always_comb begin
    w_mul  = 1'b0;
    w_div  = 1'b0;
    w_sgn  = 1'b0;
    w_mthi = 1'b0;
    w_mtlo = 1'b0;
    case (req_op)
      MDU_OP_MULT:  begin w_mul = 1'b1; w_sgn = 1'b1; end
      MDU_OP_MULTU: w_mul = 1'b1;
      MDU_OP_DIV:   begin w_div = 1'b1; w_sgn = 1'b1; end
      MDU_OP_DIVU:  w_div = 1'b1;
      MDU_OP_MTHI:  w_mthi = 1'b1;
      MDU_OP_MTLO:  w_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign w_take   = (r_state == IDLE) & req_valid & ~flush;
  assign w_start  = w_take & (w_mul | w_div);
  assign w_fix_wr = (r_state == FIX) & ~flush;

  mdu_sign_fix #(.N(WIDTH)) u_abs1 (
    .i_val (Op1),
    .i_neg (w_sgn & Op1[WIDTH-1]),
    .o_val (w_abs1)
  );

  mdu_sign_fix #(.N(WIDTH)) u_abs2 (
    .i_val (Op2),
    .i_neg (w_sgn & Op2[WIDTH-1]),
    .o_val (w_abs2)
  );

  // Multiply: acc = {partial, multiplier}; add on lsb, shift right.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_b} : '0);

  // Divide: acc = {remainder, dividend/quotient}; shift left,
  // trial-subtract, restore on borrow.
  assign w_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_b};
  assign w_qbit = ~w_diff[WIDTH];

  assign w_acc_nxt = r_is_div
    ? {(w_qbit ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0]),
       r_acc[WIDTH-2:0], w_qbit}
    : {w_sum, r_acc[WIDTH-1:1]};

  mdu_sign_fix #(.N(2*WIDTH)) u_prod (
    .i_val (r_acc),
    .i_neg (r_neg_q),
    .o_val (w_prod)
  );

  mdu_sign_fix #(.N(WIDTH)) u_quo (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_neg_q),
    .o_val (w_quo)
  );

  mdu_sign_fix #(.N(WIDTH)) u_rem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_neg_r),
    .o_val (w_rem)
  );

  // Divide by zero leaves the dividend as remainder on its own;
  // only the quotient needs forcing.
  assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div
    ? (r_div0 ? DIV0_LO : w_quo)
    : w_prod[WIDTH-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next = CALC;
      CALC: begin
        if (flush)
          w_next = IDLE;
        else if (r_cnt == '0)
          w_next = FIX;
      end
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix_wr;
      if (w_start) begin
        r_cnt    <= CNT_W'(WIDTH-1);
        r_is_div <= w_div;
        r_neg_q  <= w_sgn & (Op1[WIDTH-1] ^ Op2[WIDTH-1]);
        r_neg_r  <= w_sgn & Op1[WIDTH-1];
        r_div0   <= w_div & (Op2 == '0);
        r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_abs1 : w_abs2)};
        r_b      <= w_div ? w_abs2 : w_abs1;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= w_acc_nxt;
      end
      if (w_take & w_mthi) r_hi <= Op1;
      if (w_take & w_mtlo) r_lo <= Op1;
      if (w_fix_wr) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state == CALC) | (r_state == FIX);
  assign done      = r_done;
  assign Stall     = busy & (req_valid | hilo_rd);
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and random checks of mdu_sequencer
// against a latency-countdown model with arithmetic results.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_op = '0;
  logic [W-1:0]  Op1 = '0;
  logic [W-1:0]  Op2 = '0;
  logic          hilo_rd = 1'b0;
  logic          flush = 1'b0;
  logic          req_ready, busy, done, Stall;
  logic [W-1:0]  HI, LO;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .Op1       (Op1),
    .Op2       (Op2),
    .hilo_rd   (hilo_rd),
    .flush     (flush),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .Stall     (Stall),
    .HI        (HI),
    .LO        (LO)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MDU_OP_MULT:  begin q = sa * sb; return q; end
      MDU_OP_MULTU: begin uq = ua * ub; return uq; end
      MDU_OP_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MDU_OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return '0;
    endcase
  endfunction

  // Model: cycles left until writeback, plus architectural HI/LO.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi   = m_phi;
            m_lo   = m_plo;
            m_done = 1'b1;
          end
        end
      end else if (req_valid && !flush) begin
        case (req_op)
          MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
            {m_phi, m_plo} = ref_res(req_op, Op1, Op2);
            m_left = W + 1;
          end
          MDU_OP_MTHI: m_hi = Op1;
          MDU_OP_MTLO: m_lo = Op1;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_left == 0);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("Stall", Stall, (m_left > 0) && (req_valid || hilo_rd));
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int t;
    req_valid = 1'b1;
    req_op    = op;
    Op1       = a;
    Op2       = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 200) begin
        chk("issue_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n, nb;
    issue(op, a, b);
    wait_done(n, nb);
    chk({name, "_lat"}, n, 34);
    chk({name, "_HI"}, HI, ehi);
    chk({name, "_LO"}, LO, elo);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 100);
      default: return $urandom();
    endcase
  endfunction

  int n, nb, ndone;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_HI", HI, 0);
    chk("rst_LO", LO, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;

    issue(MDU_OP_MULT, 32'd7, 32'hFFFFFFFD);
    wait_done(n, nb);
    chk("mult_lat", n, 34);
    chk("mult_busy_cycles", nb, 33);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFEB);
    @(posedge clk);
    #1;

    run_op("divu", MDU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", MDU_OP_DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div0", MDU_OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_ovf", MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 32'h80000000);

    issue(MDU_OP_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mthi_HI", HI, 32'h1234);
    chk("mthi_done", done, 0);
    @(posedge clk);
    #1;
    run_op("multu", MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h1);

    issue(MDU_OP_MULT, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    hilo_rd   = 1'b1;
    req_valid = 1'b1;
    req_op    = MDU_OP_MULT;
    Op1       = 32'd6;
    Op2       = 32'd7;
    @(negedge clk);
    chk("hold_stall", Stall, 1);
    wait_done(n, nb);
    chk("hold_done_stall", Stall, 0);
    chk("hold_done_ready", req_ready, 1);
    chk("hold_LO1", LO, 32'd15);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hilo_rd   = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    wait_done(n, nb);
    chk("b2b_HI", HI, 32'd0);
    chk("b2b_LO", LO, 32'd42);
    @(posedge clk);
    #1;

    issue(MDU_OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", req_ready, 1);
    chk("flush_HI", HI, 32'd0);
    chk("flush_LO", LO, 32'd42);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    @(posedge clk);
    #1;

    issue(MDU_OP_DIV, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst20_ready", req_ready, 1);
    chk("rst20_HI", HI, 32'd0);
    chk("rst20_LO", LO, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst20_no_done", ndone, 0);
    @(posedge clk);
    #1;
    run_op("div_fresh", MDU_OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333);
    run_op("div_nfresh", MDU_OP_DIV, 32'hFFFFFC18, 32'd3,
           32'hFFFFFFFF, 32'hFFFFFEB3);

    ndone = 0;
    for (int i = 0; i < 6000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      hilo_rd   = ($urandom_range(0, 4) == 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_op    = 3'($urandom_range(0, 7));
      Op1       = rnd_opnd();
      Op2       = rnd_opnd();
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("rand_dones_seen", ndone > 0, 1);
    rst_n     = 1'b1;
    flush     = 1'b0;
    hilo_rd   = 1'b0;
    req_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit with HI/LO registers, sitting beside the EXE-stage ALU.
- Replaces the single-cycle combinational mult/div paths with a 32-iteration shift-add multiplier and a restoring divider.
- Sequences operand capture, iteration, sign fix-up and HI/LO writeback.
- Drives a stall to the pipeline controller while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  1  EXE stage presents an MDU operation this cycle.
- req_op  in  3  operation code:
  - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 000 and 111 are no-ops.
- Op1  in  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- Op2  in  WIDTH  rt value (multiplier / divisor).
- hilo_rd  in  1  EXE stage holds MFHI/MFLO this cycle.
- flush  in  1  kill any in-flight operation (branch or exception).
- req_ready  out  1  high only in IDLE.
- busy  out  1  high in CALC or FIX.
- done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- Stall  out  1  busy & (req_valid | hilo_rd).
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, HI = LO = 0, counter = 0, done = 0.
  - Any operation in progress is aborted mid-flight with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - On req_valid with MULT/MULTU/DIV/DIVU and flush = 0, capture the operands:
    - For signed ops, capture |Op1| and |Op2| plus sign flags.
    - For unsigned ops, capture the raw values.
  - Clear the accumulator, load counter = WIDTH-1, go to CALC.
  - MTHI/MTLO write HI/LO from Op1 at that edge; stay in IDLE; no done pulse.
  - Invalid/no-op codes are ignored.
- CALC:
  - One iteration per cycle:
    - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract giving one quotient bit per cycle.
  - Counter decrements each cycle; go to FIX after the iteration with counter = 0, i.e. exactly WIDTH cycles.
- FIX:
  - Apply sign correction:
    - Product is negated when the sign flags differ.
    - Quotient is negated when the sign flags differ; remainder takes the dividend's sign.
  - Write HI (product high half / remainder) and LO (product low half / quotient).
  - Go to IDLE; done = 1 in the following cycle.
- Latency: request accepted at edge 0; busy high for WIDTH+1 cycles (33); done and the new HI/LO visible in cycle WIDTH+2 (34).
- Divide by zero (Op2 = 0, DIV or DIVU):
  - Full latency is still taken.
  - Result: LO = all ones, HI = original Op1; done is pulsed.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no trap.
- Busy behaviour:
  - A new req_valid or hilo_rd raises Stall.
  - The requester holds its inputs; the request is accepted in the first IDLE cycle (the cycle done is high).
  - A back-to-back op is therefore accepted at the edge ending the done cycle.
- Flush:
  - Flush in CALC or FIX returns to IDLE at the next edge; HI/LO unchanged; no done pulse.
  - Flush in IDLE together with req_valid: the request is dropped.
  - Flush takes priority over FIX writeback.
- busy, req_ready and done are derived from registered state; there is no combinational path from req_* to req_ready.

Decomposition:
- Shared package mdu_pkg holds:
  - MDU_OP_* opcode constants (3-bit).
  - State enum: IDLE / CALC / FIX.
  - DIV0_LO constant (all ones).
- One natural sub-module: mdu_sign_fix, combinational absolute-value and conditional two's-complement negation, instantiated for operand capture and for result fix-up.

Test Plan:
- MULT 7 × -3 → after 34 cycles: done = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; busy high for exactly 33 cycles.
- DIVU 100 / 7 → LO = 14, HI = 2. DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 5 / 0 → LO = 0xFFFFFFFF, HI = 5 after full latency. DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- MTHI 0x1234 then MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - After MTHI: HI = 0x1234 next cycle, no done.
  - After MULTU: HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT issued with hilo_rd asserted 5 cycles later:
  - Stall high until the done cycle.
  - A second MULT held on req_valid is accepted at the end of the done cycle.
- Flush at CALC cycle 10, and separately rst_n low at cycle 20 of a DIV:
  - Both return to IDLE next edge, with no done.
  - Flush leaves HI/LO at their prior values; reset clears them to 0.
  - A fresh op then completes normally.
